// File: rtl/sap_pkg.sv
// Shared definitions for the program-mode RAM loader: bus widths and
// the loader state encoding.
package sap_pkg;

    localparam int SAP_ADDR_W = 4;
    localparam int SAP_DATA_W = 8;
    localparam int SAP_DEPTH  = 2 ** SAP_ADDR_W;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

endpackage

// File: rtl/program_loader.sv
// Writer side of the CPU program-mode RAM port: accepts a length/payload/checksum
// byte frame and writes the payload into RAM while holding the CPU in reset.
module program_loader
    import sap_pkg::*;
#(
    parameter int ADDR_W = SAP_ADDR_W,
    parameter int DATA_W = SAP_DATA_W,
    parameter int DEPTH  = SAP_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              pr_mode,
    output logic [ADDR_W-1:0] pr_address,
    output logic [DATA_W-1:0] pr_data,
    output logic              pr_write,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = ADDR_W + 1;

    state_t              state_r;
    state_t              next_s;
    logic [CNT_W-1:0]    count_r;
    logic [DATA_W-1:0]   sum_r;
    logic [ADDR_W-1:0]   addr_r;
    logic                in_ready_r;
    logic                pr_mode_r;
    logic [ADDR_W-1:0]   pr_address_r;
    logic [DATA_W-1:0]   pr_data_r;
    logic                pr_write_r;
    logic                cpu_rst_r;
    logic                busy_r;
    logic                done_r;
    logic                err_r;
    logic                xfer_s;
    logic                hdr_ok_s;
    logic                last_s;
    logic                loading_s;

    assign xfer_s   = in_valid && in_ready_r;
    assign hdr_ok_s = (in_data != {DATA_W{1'b0}}) && (in_data <= DATA_W'(DEPTH));
    assign last_s   = (count_r == CNT_W'(1));

    // Next-state decode; start is only honoured outside an active load.
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) next_s = ST_HDR;
                else       next_s = ST_IDLE;
            end
            ST_HDR: begin
                if (xfer_s) next_s = hdr_ok_s ? ST_DATA : ST_ERR;
                else        next_s = ST_HDR;
            end
            ST_DATA: begin
                if (xfer_s && last_s) next_s = ST_CSUM;
                else                  next_s = ST_DATA;
            end
            ST_CSUM: begin
                if (xfer_s) next_s = (in_data == sum_r) ? ST_DONE : ST_ERR;
                else        next_s = ST_CSUM;
            end
            ST_DONE: begin
                if (start) next_s = ST_HDR;
                else       next_s = ST_IDLE;
            end
            ST_ERR: begin
                if (start) next_s = ST_ERR == ST_ERR ? ST_HDR : ST_ERR;
                else       next_s = ST_ERR;
            end
            default: next_s = ST_IDLE;
        endcase
    end

    assign loading_s = (next_s == ST_HDR) || (next_s == ST_DATA) || (next_s == ST_CSUM);

    // State register and status outputs, registered from the upcoming state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            in_ready_r <= 1'b0;
            pr_mode_r  <= 1'b0;
            busy_r     <= 1'b0;
            cpu_rst_r  <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= next_s;
            in_ready_r <= loading_s;
            pr_mode_r  <= loading_s;
            busy_r     <= loading_s;
            cpu_rst_r  <= loading_s || (next_s == ST_ERR);
            done_r     <= (next_s == ST_DONE);
            err_r      <= (next_s == ST_ERR);
        end
    end

    // Length counter, running checksum, write address and the RAM write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r      <= {CNT_W{1'b0}};
            sum_r        <= {DATA_W{1'b0}};
            addr_r       <= {ADDR_W{1'b0}};
            pr_address_r <= {ADDR_W{1'b0}};
            pr_data_r    <= {DATA_W{1'b0}};
            pr_write_r   <= 1'b0;
        end else begin
            pr_write_r <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        count_r <= {CNT_W{1'b0}};
                        sum_r   <= {DATA_W{1'b0}};
                        addr_r  <= {ADDR_W{1'b0}};
                    end
                end
                ST_HDR: begin
                    if (xfer_s) begin
                        count_r <= in_data[CNT_W-1:0];
                        sum_r   <= in_data;
                    end
                end
                ST_DATA: begin
                    // addr_r may roll over after the last word of a full load;
                    // pr_address keeps the final DEPTH-1 value.
                    if (xfer_s) begin
                        pr_address_r <= addr_r;
                        pr_data_r    <= in_data;
                        pr_write_r   <= 1'b1;
                        sum_r        <= sum_r + in_data;
                        addr_r       <= addr_r + ADDR_W'(1);
                        count_r      <= count_r - CNT_W'(1);
                    end
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_r;
    assign pr_mode    = pr_mode_r;
    assign pr_address = pr_address_r;
    assign pr_data    = pr_data_r;
    assign pr_write   = pr_write_r;
    assign cpu_rst    = cpu_rst_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign err        = err_r;

endmodule
